haahalia_adder: RTL and testbench
=================================

Name: haahalia_adder

Overview:
- Tiny Tapeout user tile, top-level wrapper tt_um_haahalia, built as an arithmetic unit composed entirely of half-adder cells.
- Four modes, selected on uio_in[1:0]:
  - 4-bit parallel half-add
  - 4-bit ripple add
  - 8-bit accumulator
  - 8-bit population count
- Result is registered onto uo_out; status flags are registered onto uio_out[7:4].

Parameters:
- WIDTH, 4, operand width; A and B are each WIDTH bits, and the accumulator is 2*WIDTH bits.

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- ena  in  1  tile enable; when low, all registers hold their value.
- ui_in  in  8  operands: A = ui_in[3:0], B = ui_in[7:4].
- uio_in  in  8  control inputs:
  - [1:0] = mode
  - [2] = acc_clr (synchronous accumulator clear)
  - [7:3] are ignored.
- uo_out  out  8  registered result.
- uio_out  out  8  registered status:
  - [4] = carry
  - [5] = wrap
  - [6] = zero
  - [7] = parity
  - [3:0] are tied to 0.
- uio_oe  out  8  constant 8'hF0: upper nibble drives outputs, lower nibble is input.

Behaviour:
- Clock and reset (already decided): one clock, clk; reset rst_n is asynchronous and active-low.
- Reset: uo_out=0, uio_out=0, accumulator=0. uio_oe is constant 8'hF0 at all times, including during reset.
- Latency: inputs sampled at rising edge N appear on uo_out/uio_out after that edge (1 cycle). No handshake.
- ena=0: uo_out, uio_out and the accumulator all hold.
- Mode 00, HALF:
  - uo_out[3:0] = A XOR B (per-bit sums).
  - uo_out[7:4] = A AND B (per-bit carries).
  - carry = |(A&B).
- Mode 01, ADD:
  - uo_out = {3'b0, A+B}, a 5-bit sum from a ripple chain of half adders.
  - carry = sum[4] (set when A+B > 15).
- Mode 10, ACC:
  - Each enabled cycle: acc <= acc + {4'b0,A}, mod 256.
  - uo_out = new acc value.
  - wrap = 1 for exactly the cycle whose addition overflowed 255; 0 otherwise.
  - carry = 0.
- Mode 11, POPCNT:
  - uo_out = number of 1 bits in ui_in (0..8), computed with a half-adder reduction tree.
  - carry = 0.
- acc_clr=1 (any mode, with ena=1): acc <= 0.
  - In ACC mode it takes precedence over the add: uo_out=0 and wrap=0.
- Accumulator is only updated in ACC mode or by acc_clr; it retains its value in the other modes.
- wrap is 0 in every mode other than ACC.
- zero = (next uo_out == 0); parity = XOR of next uo_out. Both are registered with the result.
- Mode change takes effect on the next edge; there is no pipeline flush.

Decomposition:
- Package haahalia_pkg holds:
  - mode constants MODE_HALF=2'b00, MODE_ADD=2'b01, MODE_ACC=2'b10, MODE_POP=2'b11
  - the uio_out status bit-index constants
  - the UIO_OE constant 8'hF0.
- Sub-module half_adder (inputs a, b; outputs s, c) is the only leaf cell.
  - It is instantiated per bit for HALF, chained for ADD and the accumulator increment, and treed for POPCNT.
- tt_um_haahalia is a thin wrapper mapping the Tiny Tapeout pins onto haahalia_adder.

Test Plan:
- Reset: rst_n=0 mid-clock -> uo_out=0 and uio_out=0 immediately (asynchronous); uio_oe=8'hF0.
- HALF: ui_in=8'hC5 (A=5, B=C), mode 00 -> uo_out=8'h49 after 1 clock; carry=1, zero=0, parity=1.
- ADD, three inputs in mode 01:
  - ui_in=8'hFF (A=F, B=F) -> uo_out=8'h1E, carry=1.
  - ui_in=8'h21 -> uo_out=8'h03, carry=0.
  - ui_in=8'h00 -> uo_out=0, zero=1.
- ACC:
  - acc_clr pulse, then mode 10 with A=F held for 17 cycles -> uo_out steps 0F,1E,...,FF.
  - The 18th cycle gives uo_out=0E with wrap=1 for that single cycle.
  - With ena=0, the accumulator holds.
- POPCNT, mode 11:
  - ui_in=8'hFF -> uo_out=8.
  - ui_in=8'hA5 -> uo_out=4.
  - ui_in=8'h00 -> uo_out=0, zero=1.
- Mode interplay:
  - acc=8'h20, switch to ADD for 3 cycles, then back to ACC with A=1 -> uo_out=8'h21; the accumulator was retained.
  - acc_clr together with mode 10 -> uo_out=0.

Source files
------------

// File: rtl/haahalia_pkg.sv
// Shared constants and types for the half-adder arithmetic tile.
package haahalia_pkg;

    // Operand width; the accumulator and result bus are twice this.
    localparam int unsigned WIDTH = 4;
    localparam int unsigned ACC_W = 2 * WIDTH;
    localparam int unsigned RES_W = 8;
    localparam int unsigned POP_W = 4;

    // Operating mode, taken from uio_in[1:0].
    typedef enum logic [1:0] {
        MODE_HALF = 2'b00,
        MODE_ADD  = 2'b01,
        MODE_ACC  = 2'b10,
        MODE_POP  = 2'b11
    } mode_e;

    // Bit positions of the status flags on uio_out.
    localparam int unsigned STAT_CARRY  = 4;
    localparam int unsigned STAT_WRAP   = 5;
    localparam int unsigned STAT_ZERO   = 6;
    localparam int unsigned STAT_PARITY = 7;

    // Upper nibble of uio is output, lower nibble is input.
    localparam logic [7:0] UIO_OE = 8'hF0;

    // Registered status flags.
    typedef struct packed {
        logic parity;
        logic zero;
        logic wrap;
        logic carry;
    } status_t;

endpackage

// File: rtl/haahalia_if.sv
// Tiny Tapeout pin bundle between the tile wrapper and the arithmetic core.
//   ena     : tile enable (master -> slave)
//   ui_in   : operands A = [3:0], B = [7:4] (master -> slave)
//   uio_in  : [1:0] mode, [2] acc_clr (master -> slave)
//   uo_out  : registered result (slave -> master)
//   uio_out : registered status in [7:4] (slave -> master)
//   uio_oe  : constant output enables (slave -> master)
interface haahalia_if;
    logic       ena;
    logic [7:0] ui_in;
    logic [7:0] uio_in;
    logic [7:0] uo_out;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;

    modport master (
        output ena, ui_in, uio_in,
        input  uo_out, uio_out, uio_oe
    );

    modport slave (
        input  ena, ui_in, uio_in,
        output uo_out, uio_out, uio_oe
    );
endinterface

// File: rtl/half_adder.sv
// Half-adder leaf cell; every arithmetic path in the tile is built from it.
//   a, b : input bits
//   s    : sum (a ^ b)
//   c    : carry (a & b)
module half_adder (
    input  logic a,
    input  logic b,
    output logic s,
    output logic c
);
    assign s = a ^ b;
    assign c = a & b;
endmodule

// File: rtl/tt_um_haahalia.sv
// Tiny Tapeout tile wrapper: maps the standard tile pins onto haahalia_adder.
//   ui_in, uio_in, ena, clk, rst_n : tile inputs
//   uo_out, uio_out, uio_oe        : tile outputs
module tt_um_haahalia (
    input  logic [7:0] ui_in,
    output logic [7:0] uo_out,
    input  logic [7:0] uio_in,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe,
    input  logic       ena,
    input  logic       clk,
    input  logic       rst_n
);
    haahalia_if u_bus ();

    assign u_bus.ena    = ena;
    assign u_bus.ui_in  = ui_in;
    assign u_bus.uio_in = uio_in;
    assign uo_out       = u_bus.uo_out;
    assign uio_out      = u_bus.uio_out;
    assign uio_oe       = u_bus.uio_oe;

    haahalia_adder u_core (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (u_bus)
    );
endmodule

// File: rtl/haahalia_adder.sv
// Arithmetic core: parallel half-add, 4-bit ripple add, 8-bit accumulator
// and 8-bit popcount, all from half_adder cells, result and flags registered.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : pin bundle (slave side), see haahalia_if
module haahalia_adder
    import haahalia_pkg::*;
(
    input  logic      clk,
    input  logic      rst_n,
    haahalia_if.slave bus
);

    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    mode_e            mode;
    logic             acc_clr;
    logic             unused_uio;

    assign op_a       = bus.ui_in[WIDTH-1:0];
    assign op_b       = bus.ui_in[2*WIDTH-1:WIDTH];
    assign mode       = mode_e'(bus.uio_in[1:0]);
    assign acc_clr    = bus.uio_in[2];
    assign unused_uio = ^bus.uio_in[7:3];

    // ---------------------------------------------------------------
    // HALF: one cell per bit pair
    // ---------------------------------------------------------------
    logic [WIDTH-1:0] half_s;
    logic [WIDTH-1:0] half_c;

    for (genvar i = 0; i < WIDTH; i++) begin : g_half
        half_adder u_ha (.a(op_a[i]), .b(op_b[i]), .s(half_s[i]), .c(half_c[i]));
    end

    // ---------------------------------------------------------------
    // ADD: ripple chain; each full-add stage is two cells, and the two
    // stage carries can never both be set, so OR merges them.
    // ---------------------------------------------------------------
    logic [WIDTH-1:0] add_s;
    logic [WIDTH:1]   add_cy;
    logic [WIDTH-1:1] add_p;
    logic [WIDTH-1:1] add_g;
    logic [WIDTH-1:1] add_t;

    half_adder u_add0 (.a(op_a[0]), .b(op_b[0]), .s(add_s[0]), .c(add_cy[1]));

    for (genvar i = 1; i < WIDTH; i++) begin : g_add
        half_adder u_ha_ab (.a(op_a[i]),  .b(op_b[i]),   .s(add_p[i]), .c(add_g[i]));
        half_adder u_ha_cy (.a(add_p[i]), .b(add_cy[i]), .s(add_s[i]), .c(add_t[i]));
        assign add_cy[i+1] = add_g[i] | add_t[i];
    end

    // ---------------------------------------------------------------
    // ACC: low nibble is a full ripple add with A; the zero-extended
    // upper nibble only has to absorb the carry, so one cell per bit.
    // ---------------------------------------------------------------
    logic [ACC_W-1:0] acc_q;
    logic [ACC_W-1:0] acc_d;
    logic [ACC_W-1:0] acc_sum;
    logic [ACC_W:1]   acc_cy;
    logic [WIDTH-1:1] acc_p;
    logic [WIDTH-1:1] acc_g;
    logic [WIDTH-1:1] acc_t;

    half_adder u_acc0 (.a(acc_q[0]), .b(op_a[0]), .s(acc_sum[0]), .c(acc_cy[1]));

    for (genvar i = 1; i < WIDTH; i++) begin : g_acc_lo
        half_adder u_ha_ab (.a(acc_q[i]), .b(op_a[i]),   .s(acc_p[i]),   .c(acc_g[i]));
        half_adder u_ha_cy (.a(acc_p[i]), .b(acc_cy[i]), .s(acc_sum[i]), .c(acc_t[i]));
        assign acc_cy[i+1] = acc_g[i] | acc_t[i];
    end

    for (genvar i = WIDTH; i < ACC_W; i++) begin : g_acc_hi
        half_adder u_ha_inc (.a(acc_q[i]), .b(acc_cy[i]), .s(acc_sum[i]), .c(acc_cy[i+1]));
    end

    // ---------------------------------------------------------------
    // POPCNT: level 1 counts bit pairs (0..2), level 2 sums pairs of
    // those (0..4), level 3 sums the two halves (0..8).
    // ---------------------------------------------------------------
    logic [3:0] l1_s;
    logic [3:0] l1_c;

    for (genvar k = 0; k < 4; k++) begin : g_pop_l1
        half_adder u_ha (.a(bus.ui_in[2*k]), .b(bus.ui_in[2*k+1]), .s(l1_s[k]), .c(l1_c[k]));
    end

    logic [2:0] l2_q [2];
    logic [1:0] l2_k0;
    logic [1:0] l2_p;
    logic [1:0] l2_g;
    logic [1:0] l2_t;

    for (genvar m = 0; m < 2; m++) begin : g_pop_l2
        half_adder u_ha_b0 (.a(l1_s[2*m]), .b(l1_s[2*m+1]), .s(l2_q[m][0]), .c(l2_k0[m]));
        half_adder u_ha_b1 (.a(l1_c[2*m]), .b(l1_c[2*m+1]), .s(l2_p[m]),    .c(l2_g[m]));
        half_adder u_ha_cy (.a(l2_p[m]),   .b(l2_k0[m]),    .s(l2_q[m][1]), .c(l2_t[m]));
        assign l2_q[m][2] = l2_g[m] | l2_t[m];
    end

    logic [POP_W-1:0] pop_cnt;
    logic [3:1]       l3_cy;
    logic [2:1]       l3_p;
    logic [2:1]       l3_g;
    logic [2:1]       l3_t;

    half_adder u_pop_l3_0 (.a(l2_q[0][0]), .b(l2_q[1][0]), .s(pop_cnt[0]), .c(l3_cy[1]));

    for (genvar i = 1; i < 3; i++) begin : g_pop_l3
        half_adder u_ha_ab (.a(l2_q[0][i]), .b(l2_q[1][i]), .s(l3_p[i]),    .c(l3_g[i]));
        half_adder u_ha_cy (.a(l3_p[i]),    .b(l3_cy[i]),   .s(pop_cnt[i]), .c(l3_t[i]));
        assign l3_cy[i+1] = l3_g[i] | l3_t[i];
    end

    assign pop_cnt[3] = l3_cy[3];

    // ---------------------------------------------------------------
    // Result / status / accumulator next-state
    // ---------------------------------------------------------------
    logic [RES_W-1:0] res_d;
    logic [RES_W-1:0] res_q;
    status_t          stat_d;
    status_t          stat_q;

    always_comb begin
        res_d  = '0;
        stat_d = '0;
        acc_d  = acc_q;

        unique case (mode)
            MODE_HALF: begin
                res_d        = {half_c, half_s};
                stat_d.carry = |half_c;
            end
            MODE_ADD: begin
                res_d        = RES_W'({add_cy[WIDTH], add_s});
                stat_d.carry = add_cy[WIDTH];
            end
            MODE_ACC: begin
                // Clear wins over the add in the same cycle.
                res_d       = acc_clr ? '0 : acc_sum;
                stat_d.wrap = ~acc_clr & acc_cy[ACC_W];
            end
            MODE_POP: begin
                res_d = RES_W'(pop_cnt);
            end
        endcase

        if (acc_clr) begin
            acc_d = '0;
        end else if (mode == MODE_ACC) begin
            acc_d = acc_sum;
        end

        stat_d.zero   = (res_d == '0);
        stat_d.parity = ^res_d;
    end

    // State registers; ena low freezes everything.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_q  <= '0;
            stat_q <= '0;
            acc_q  <= '0;
        end else if (bus.ena) begin
            res_q  <= res_d;
            stat_q <= stat_d;
            acc_q  <= acc_d;
        end
    end

    // Place registered flags on their uio_out bits.
    logic [7:0] uio_status;

    always_comb begin
        uio_status              = '0;
        uio_status[STAT_CARRY]  = stat_q.carry;
        uio_status[STAT_WRAP]   = stat_q.wrap;
        uio_status[STAT_ZERO]   = stat_q.zero;
        uio_status[STAT_PARITY] = stat_q.parity;
    end

    assign bus.uo_out  = res_q;
    assign bus.uio_out = uio_status;
    assign bus.uio_oe  = UIO_OE;

endmodule

// File: tb/tb_haahalia_adder.sv
// Directed bench for haahalia_adder: reset, all four modes, accumulator
// wrap, enable hold and mode interplay.
module tb_haahalia_adder;
    import haahalia_pkg::*;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_errors;

    haahalia_if bus ();

    haahalia_adder u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %02h expected %02h", tag, got, exp);
        end
    endtask

    // Advance one rising edge and settle just after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [7:0] ui, input mode_e mode, input logic clr);
        bus.ui_in  = ui;
        bus.uio_in = {5'b0, clr, mode};
    endtask

    int         acc_model;
    int         sum;
    logic [7:0] exp_uio;

    initial begin
        n_checks   = 0;
        n_errors   = 0;
        clk        = 1'b0;
        rst_n      = 1'b0;
        bus.ena    = 1'b1;
        drive(8'h00, MODE_HALF, 1'b0);

        #12;
        check("reset_uo", bus.uo_out, 8'h00);
        check("reset_uio", bus.uio_out, 8'h00);
        check("reset_oe", bus.uio_oe, 8'hF0);
        rst_n = 1'b1;
        tick();

        // HALF
        drive(8'hC5, MODE_HALF, 1'b0); tick();
        check("half_c5_uo", bus.uo_out, 8'h49);
        check("half_c5_uio", bus.uio_out, 8'h90);
        drive(8'hA5, MODE_HALF, 1'b0); tick();
        check("half_a5_uo", bus.uo_out, 8'h0F);
        check("half_a5_uio", bus.uio_out, 8'h00);

        // ADD
        drive(8'hFF, MODE_ADD, 1'b0); tick();
        check("add_ff_uo", bus.uo_out, 8'h1E);
        check("add_ff_uio", bus.uio_out, 8'h10);
        drive(8'h21, MODE_ADD, 1'b0); tick();
        check("add_21_uo", bus.uo_out, 8'h03);
        check("add_21_uio", bus.uio_out, 8'h00);
        drive(8'h00, MODE_ADD, 1'b0); tick();
        check("add_00_uo", bus.uo_out, 8'h00);
        check("add_00_uio", bus.uio_out, 8'h40);

        // ACC: clear, then add 0xF eighteen times
        drive(8'h0F, MODE_ACC, 1'b1); tick();
        check("acc_clr_uo", bus.uo_out, 8'h00);
        check("acc_clr_uio", bus.uio_out, 8'h40);
        acc_model = 0;
        drive(8'h0F, MODE_ACC, 1'b0);
        for (int i = 1; i <= 18; i++) begin
            tick();
            sum       = acc_model + 15;
            acc_model = sum % 256;
            check($sformatf("acc_step%0d_uo", i), bus.uo_out, 8'(acc_model));
            check($sformatf("acc_step%0d_wrap", i), {7'b0, bus.uio_out[STAT_WRAP]},
                  (sum > 255) ? 8'h01 : 8'h00);
        end
        check("acc_wrap_uio", bus.uio_out, 8'hA0);
        tick();
        check("acc_after_wrap_uo", bus.uo_out, 8'h1D);
        check("acc_after_wrap_uio", bus.uio_out, 8'h00);

        // ena low: everything holds, even with a clear pending
        bus.ena = 1'b0;
        drive(8'h01, MODE_ACC, 1'b1);
        repeat (3) tick();
        check("hold_uo", bus.uo_out, 8'h1D);
        check("hold_uio", bus.uio_out, 8'h00);
        bus.ena = 1'b1;
        drive(8'h01, MODE_ACC, 1'b0); tick();
        check("hold_resume_uo", bus.uo_out, 8'h1E);

        // POPCNT
        drive(8'hFF, MODE_POP, 1'b0); tick();
        check("pop_ff_uo", bus.uo_out, 8'h08);
        check("pop_ff_uio", bus.uio_out, 8'h80);
        drive(8'hA5, MODE_POP, 1'b0); tick();
        check("pop_a5_uo", bus.uo_out, 8'h04);
        check("pop_a5_uio", bus.uio_out, 8'h80);
        drive(8'h00, MODE_POP, 1'b0); tick();
        check("pop_00_uo", bus.uo_out, 8'h00);
        check("pop_00_uio", bus.uio_out, 8'h40);

        // Mode interplay: build acc=0x20, detour through ADD, resume
        drive(8'h0F, MODE_ACC, 1'b1); tick();
        drive(8'h0F, MODE_ACC, 1'b0); tick();
        drive(8'h0F, MODE_ACC, 1'b0); tick();
        drive(8'h02, MODE_ACC, 1'b0); tick();
        check("mix_acc20_uo", bus.uo_out, 8'h20);
        drive(8'h21, MODE_ADD, 1'b0);
        repeat (3) tick();
        check("mix_add_uo", bus.uo_out, 8'h03);
        check("mix_add_uio", bus.uio_out, 8'h00);
        drive(8'h01, MODE_ACC, 1'b0); tick();
        check("mix_resume_uo", bus.uo_out, 8'h21);
        exp_uio = 8'h00;
        check("mix_resume_uio", bus.uio_out, exp_uio);
        drive(8'h0F, MODE_ACC, 1'b1); tick();
        check("mix_clr_uo", bus.uo_out, 8'h00);
        check("mix_clr_uio", bus.uio_out, 8'h40);

        // Asynchronous reset between edges
        drive(8'h07, MODE_ACC, 1'b0); tick();
        check("pre_rst_uo", bus.uo_out, 8'h07);
        check("pre_rst_uio", bus.uio_out, 8'h80);
        #3;
        rst_n = 1'b0;
        #1;
        check("async_rst_uo", bus.uo_out, 8'h00);
        check("async_rst_uio", bus.uio_out, 8'h00);
        check("async_rst_oe", bus.uio_oe, 8'hF0);
        @(negedge clk);
        rst_n = 1'b1;
        drive(8'h01, MODE_ACC, 1'b0); tick();
        check("post_rst_acc_uo", bus.uo_out, 8'h01);
        check("post_rst_acc_uio", bus.uio_out, 8'h80);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
